apb_slave_regbank: RTL and testbench
====================================

# apb_slave_regbank

- Parametrised APB4 completer (slave) fronting a bank of `NUM_REGS` software-visible registers.
- Data width, address width, wait states, read-only and privileged masks are all configurable.
- Supports byte strobes, wait-state insertion and error response (`PSLVERR`).
- Sits directly on the `apb_intf` bus signals; exposes register contents to, and takes read-only status from, the surrounding hardware.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: PADDR width.
- `DATA_WIDTH`, default 32: PWDATA/PRDATA width. Must be 8, 16, 32 or 64.
- `NUM_REGS`, default 8: number of registers, 1..2^(ADDR_WIDTH-OFS), where OFS = log2(DATA_WIDTH/8).
- `WAIT_STATES`, default 0: access-phase cycles with PREADY=0 before completion, 0..15.
- `RO_MASK`, default 0: NUM_REGS bits; bit i=1 makes register i read-only, sourced from `hw_in`.
- `PRIV_MASK`, default 0: NUM_REGS bits; bit i=1 makes register i privileged-only.
- `RESET_VAL`, default 0: DATA_WIDTH reset value of every RW register.

Ports:
- `PCLK`, in, 1: clock. All logic on the rising edge.
- `PRESET`, in, 1: reset, synchronous and active-high.
- `PSEL`, in, 1: select.
- `PENABLE`, in, 1: access phase.
- `PPROT`, in, 3: protection. Only bit 0 is used (1 = privileged).
- `PWRITE`, in, 1: 1 = write.
- `PSTRB`, in, DATA_WIDTH/8: write byte strobes.
- `PADDR`, in, ADDR_WIDTH: byte address.
- `PWDATA`, in, DATA_WIDTH: write data.
- `PRDATA`, out, DATA_WIDTH: read data, registered.
- `PREADY`, out, 1: transfer complete, registered.
- `PSLVERR`, out, 1: error, registered, valid only while PREADY=1.
- `reg_q`, out, NUM_REGS*DATA_WIDTH: RW register contents, register i at slice [i*DATA_WIDTH +: DATA_WIDTH]. RO slices read as 0.
- `hw_in`, in, NUM_REGS*DATA_WIDTH: read value for RO registers. Ignored for RW registers.

## Operation

- **Decode.**
  - index = PADDR[ADDR_WIDTH-1:OFS].
  - Misaligned when PADDR[OFS-1:0] != 0 (no check when OFS = 0).
- **Error.** A transfer is an error if any of the following hold:
  - index >= NUM_REGS;
  - the address is misaligned;
  - it is a write to an RO register;
  - PPROT[0]=0 and PRIV_MASK[index]=1.
- **Capture.** PADDR, PWRITE, PWDATA, PSTRB and PPROT[0] are captured at the end of the setup cycle (PSEL=1, PENABLE=0). Changes to them during the access phase are ignored.
- **FSM states.**
  - IDLE → (setup seen) → WAIT, or → RESP when WAIT_STATES=0.
  - WAIT: counter counts 1..WAIT_STATES; on reaching WAIT_STATES → RESP.
  - RESP → IDLE. RESP is the cycle with PREADY=1.
  - WAIT with PSEL=0 (aborted transfer) → IDLE. No write, no response.
- **Write, no error.** At the end of the RESP cycle, byte lane b of register index is updated only when PSTRB[b]=1; other lanes are held.
- **Write, error.** No register changes.
- **Read, no error.** PRDATA = register value, or hw_in slice if RO. PSTRB is ignored on reads.
- **Read, error.** PRDATA = 0.
- **Outside RESP.** PRDATA=0, PREADY=0, PSLVERR=0.
- **Reset.** A reset asserted at any time, including mid-transfer, forces:
  - FSM to IDLE and the wait counter to 0;
  - every RW register to RESET_VAL;
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - A pending write is discarded.

## Timing

- Setup cycle T0, first access cycle T1.
- PREADY=1 during cycle T1+WAIT_STATES. Total transfer = 2+WAIT_STATES cycles.
- PREADY, PSLVERR and PRDATA are asserted by the edge ending the previous cycle and deasserted by the edge ending RESP.
- A write is visible on reg_q the cycle after RESP.
- Back-to-back transfers: a new setup phase may occupy the cycle immediately after RESP. No dead cycle is added.
- A setup phase seen while not in IDLE is a protocol violation. It is ignored; the current transfer continues.
- PSEL=1 with PENABLE=1 in IDLE (no prior setup) is ignored.

## Test plan

- **Reset values.** Assert PRESET 2 cycles with defaults → all outputs 0; reg_q all RESET_VAL; read of reg 3 returns 0x00000000 with PSLVERR=0.
- **Strobed write then read.** WAIT_STATES=0. Write 0xDEADBEEF to 0x04 with PSTRB=0b0101, then read 0x04 → PREADY in 2nd cycle of each transfer; PRDATA=0x00AD00EF; reg_q[63:32]=0x00AD00EF.
- **Wait states.** WAIT_STATES=3. Read 0x00 → PREADY low for 3 access cycles, high on the 4th; total 5 cycles.
- **Error responses.**
  - NUM_REGS=8, read 0x20 → PSLVERR=1, PRDATA=0.
  - Write 0x02 → PSLVERR=1, no register change.
  - RO_MASK=0x04, write 0x08 → PSLVERR=1.
  - RO_MASK=0x04, read 0x08 with hw_in slice 2 = 0x1234 → PRDATA=0x1234, PSLVERR=0.
- **Privilege.** PRIV_MASK=0x01.
  - Write 0x00 with PPROT=3'b000 → PSLVERR=1, reg 0 unchanged.
  - Same write with PPROT=3'b001 → succeeds.
- **Abort and reset mid-transfer.** WAIT_STATES=4.
  - Write 0xFFFFFFFF to 0x00, drop PSEL in the 2nd WAIT cycle → IDLE; reg 0 unchanged; no PREADY pulse.
  - Repeat and assert PRESET in a WAIT cycle → outputs 0 next cycle; reg 0 = RESET_VAL.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB4 completer fronting a bank of software-visible registers
// Byte strobes, configurable wait states, RO/privileged masks and PSLVERR responses.
module apb_slave_regbank #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]   PRIV_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [2:0]                     PPROT,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in
);

  localparam int         NB    = DATA_WIDTH / 8;
  localparam int         OFS   = $clog2(NB);
  localparam int         IDX_W = ADDR_WIDTH - OFS;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic                    priv_q, priv_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    setup;
  logic                    complete;
  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic                    dec_write;
  logic                    dec_priv;
  logic [IDX_W-1:0]        dec_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic                    misalign;
  logic                    hit;
  logic                    hit_ro;
  logic                    hit_priv;
  logic [DATA_WIDTH-1:0]   hit_data;
  logic                    dec_err;
  logic                    unused_pprot;

  assign unused_pprot = ^PPROT[2:1];
  assign setup        = PSEL && !PENABLE;

  // With zero wait states the response is built from the live setup-phase bus;
  // otherwise from the copy captured at the end of setup.
  assign dec_addr  = (state_q == S_IDLE) ? PADDR    : addr_q;
  assign dec_write = (state_q == S_IDLE) ? PWRITE   : write_q;
  assign dec_priv  = (state_q == S_IDLE) ? PPROT[0] : priv_q;
  assign dec_idx   = dec_addr[ADDR_WIDTH-1:OFS];
  assign wr_idx    = addr_q[ADDR_WIDTH-1:OFS];

  generate
    if (OFS > 0) begin : g_align
      assign misalign = |dec_addr[OFS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    hit_ro   = 1'b0;
    hit_priv = 1'b0;
    hit_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(dec_idx) == i) begin
        hit      = 1'b1;
        hit_ro   = RO_MASK[i];
        hit_priv = PRIV_MASK[i];
        hit_data = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  assign dec_err = !hit || misalign || (dec_write && hit_ro) || (!dec_priv && hit_priv);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    priv_d    = priv_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    complete  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          priv_d  = PPROT[0];
          if (WS == 4'd0) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS) begin
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d   = S_RESP;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (!dec_write && !dec_err) ? hit_data : '0;
    end
  end

  // Writes commit at the end of RESP, one byte lane per strobe bit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (state_q == S_RESP && write_q && !pslverr_q && !RO_MASK[i] && 32'(wr_idx) == i) begin
        for (int b = 0; b < NB; b++) begin
          if (strb_q[b]) begin
            regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      priv_q    <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      priv_q    <= priv_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - directed scoreboard bench for apb_slave_regbank
// Three instances cover the zero-wait/mask, 3-wait and 4-wait (abort/reset) configurations.
module tb_apb_slave_regbank;

  logic         clk = 1'b0;
  logic         preset;
  logic         psel_a, psel_b, psel_c;
  logic         penable;
  logic [2:0]   pprot;
  logic         pwrite;
  logic [3:0]   pstrb;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [255:0] hw_in;

  logic [31:0]  prdata_a, prdata_b, prdata_c;
  logic         pready_a, pready_b, pready_c;
  logic         pslverr_a, pslverr_b, pslverr_c;
  logic [255:0] reg_q_a, reg_q_b, reg_q_c;

  int           sel;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;

  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ws;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] RV_B = 32'h0BAD_F00D;
  localparam logic [31:0] RV_C = 32'h5A5A_0000;

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_STATES(0), .RO_MASK(8'h04), .PRIV_MASK(8'h01)) dut_a (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_a), .PENABLE(penable), .PPROT(pprot),
    .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a), .reg_q(reg_q_a), .hw_in(hw_in));

  apb_slave_regbank #(.WAIT_STATES(3), .RESET_VAL(RV_B)) dut_b (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_b), .PENABLE(penable), .PPROT(pprot),
    .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b), .reg_q(reg_q_b), .hw_in(hw_in));

  apb_slave_regbank #(.WAIT_STATES(4), .RESET_VAL(RV_C)) dut_c (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_c), .PENABLE(penable), .PPROT(pprot),
    .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_c), .PREADY(pready_c), .PSLVERR(pslverr_c), .reg_q(reg_q_c), .hw_in(hw_in));

  always_comb begin
    m_rdata = prdata_a;
    m_ready = pready_a;
    m_err   = pslverr_a;
    if (sel == 1) begin
      m_rdata = prdata_b;
      m_ready = pready_b;
      m_err   = pslverr_b;
    end else if (sel == 2) begin
      m_rdata = prdata_c;
      m_ready = pready_c;
      m_err   = pslverr_c;
    end
  end

  task automatic check(input logic [255:0] obs, input logic [255:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends RESP.
  task automatic xfer(input int dut, input logic wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_ws,
                      input string tag);
    exp_t e;
    int   waits;
    bit   done;
    bit   noisy;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, ws: exp_ws});
    sel     = dut;
    psel_a  = (dut == 0);
    psel_b  = (dut == 1);
    psel_c  = (dut == 2);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    done    = 1'b0;
    noisy   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (m_ready) begin
        e = exp_q.pop_front();
        check(m_err, e.err, {tag, " pslverr"});
        check(m_rdata, e.rdata, {tag, " prdata"});
        check(waits, e.ws, {tag, " wait cycles"});
        done = 1'b1;
      end else begin
        if (m_rdata !== 32'h0 || m_err !== 1'b0) noisy = 1'b1;
        waits++;
        if (waits > 20) begin
          check(1'b0, 1'b1, {tag, " pready timeout"});
          void'(exp_q.pop_front());
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    check(noisy, 1'b0, {tag, " outputs quiet before pready"});
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    psel_c  = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    bit saw_ready;
    preset  = 1'b1;
    sel     = 0;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    psel_c  = 1'b0;
    penable = 1'b0;
    pprot   = 3'b000;
    pwrite  = 1'b0;
    pstrb   = 4'h0;
    paddr   = 8'h00;
    pwdata  = 32'h0;
    hw_in   = '0;
    hw_in[2*32 +: 32] = 32'h0000_1234;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check({pready_a, pslverr_a, prdata_a}, 34'h0, "reset outputs a");
    check({pready_b, pslverr_b, prdata_b}, 34'h0, "reset outputs b");
    check(reg_q_a, 256'h0, "reset reg_q a");
    check(reg_q_b, {8{RV_B}}, "reset reg_q b");
    check(reg_q_c, {8{RV_C}}, "reset reg_q c");
    @(posedge clk); #1;
    preset = 1'b0;

    xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF, 3'b000, 32'h0000_0000, 1'b0, 0, "read reg3 after reset");
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101, 3'b000, 32'h0, 1'b0, 0, "strobed write");
    check(reg_q_a[63:32], 32'h00AD_00EF, "reg_q reg1 after strobed write");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b000, 32'h00AD_00EF, 1'b0, 0, "read back reg1");
    xfer(0, 1'b0, 8'h20, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1, 0, "read out of range");
    xfer(0, 1'b1, 8'h00, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, 1'b1, 0, "unprivileged write");
    check(reg_q_a[31:0], 32'h0, "reg0 after unprivileged write");
    xfer(0, 1'b1, 8'h00, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0, 1'b0, 0, "privileged write");
    check(reg_q_a[31:0], 32'hCAFE_F00D, "reg0 after privileged write");
    xfer(0, 1'b1, 8'h02, 32'h1234_5678, 4'hF, 3'b001, 32'h0, 1'b1, 0, "misaligned write");
    check(reg_q_a[31:0], 32'hCAFE_F00D, "reg0 after misaligned write");
    xfer(0, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 0, "write to RO");
    check(reg_q_a[95:64], 32'h0, "RO slice of reg_q");
    xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, 3'b000, 32'h0000_1234, 1'b0, 0, "read RO from hw_in");
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1, 0, "unprivileged read");
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 3'b001, 32'hCAFE_F00D, 1'b0, 0, "privileged read");

    xfer(1, 1'b0, 8'h00, 32'h0, 4'hF, 3'b000, RV_B, 1'b0, 3, "ws3 read reg0");
    xfer(1, 1'b0, 8'h1C, 32'h0, 4'hF, 3'b000, RV_B, 1'b0, 3, "ws3 read reg7");

    xfer(2, 1'b1, 8'h00, 32'h1122_3344, 4'hF, 3'b000, 32'h0, 1'b0, 4, "ws4 write reg0");
    check(reg_q_c[31:0], 32'h1122_3344, "ws4 reg0 after write");

    // Abort: PSEL dropped during the second WAIT cycle.
    sel = 2; psel_c = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_c = 1'b0; penable = 1'b0;
    saw_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pready_c) saw_ready = 1'b1;
    end
    check(saw_ready, 1'b0, "abort no pready");
    check(reg_q_c[31:0], 32'h1122_3344, "abort reg0 unchanged");
    @(posedge clk); #1;

    // Reset asserted during the second WAIT cycle of a write.
    psel_c = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0; psel_c = 1'b0; penable = 1'b0;
    @(negedge clk);
    check({pready_c, pslverr_c, prdata_c}, 34'h0, "outputs after mid-transfer reset");
    check(reg_q_c[31:0], RV_C, "reg0 after mid-transfer reset");
    check(reg_q_a[63:32], 32'h0, "dut_a reg1 after reset");
    saw_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pready_c) saw_ready = 1'b1;
    end
    check(saw_ready, 1'b0, "no pready after reset");
    check(reg_q_c[31:0], RV_C, "pending write discarded");
    check(exp_q.size(), 0, "scoreboard drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
